// File: rtl/pipe_stage_buf.sv
// Pipeline split register with valid/ready handshake and a 2-entry skid buffer.
// Flush drops all held and offered ops and clears the side-effect control bits in KILL_MASK.
module pipe_stage_buf #(
   parameter int unsigned          DBITS      = 32,
   parameter int unsigned          CTRL_BITS  = 4,
   parameter int unsigned          DATA_WORDS = 4,
   parameter logic [CTRL_BITS-1:0] KILL_MASK  = 4'b1010
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CTRL_BITS-1:0]        in_ctrl,
   input  logic [DATA_WORDS*DBITS-1:0] in_data,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [CTRL_BITS-1:0]        out_ctrl,
   output logic [DATA_WORDS*DBITS-1:0] out_data,
   output logic [1:0]                  occupancy
);

   localparam int unsigned DW = DATA_WORDS * DBITS;

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t                r_state;
   logic                  r_out_valid;
   logic                  r_in_ready;
   logic [1:0]            r_occ;
   logic [CTRL_BITS-1:0]  r_main_ctrl;
   logic [DW-1:0]         r_main_data;
   logic [CTRL_BITS-1:0]  r_skid_ctrl;
   logic [DW-1:0]         r_skid_data;

   logic w_accept;
   logic w_emit;

   assign w_accept = in_valid & r_in_ready;
   assign w_emit   = r_out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occ       <= 2'd0;
         r_main_ctrl <= '0;
         r_main_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else if (flush) begin
         // Data words are left in place; only the side-effect bits must die.
         r_state     <= S_EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_occ       <= 2'd0;
         r_main_ctrl <= r_main_ctrl & ~KILL_MASK;
         r_skid_ctrl <= r_skid_ctrl & ~KILL_MASK;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_accept) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
                  r_out_valid <= 1'b1;
                  r_occ       <= 2'd1;
                  r_state     <= S_ONE;
               end
            end
            S_ONE: begin
               if (w_accept && w_emit) begin
                  r_main_ctrl <= in_ctrl;
                  r_main_data <= in_data;
               end else if (w_accept) begin
                  r_skid_ctrl <= in_ctrl;
                  r_skid_data <= in_data;
                  r_in_ready  <= 1'b0;
                  r_occ       <= 2'd2;
                  r_state     <= S_TWO;
               end else if (w_emit) begin
                  r_main_ctrl <= r_main_ctrl & ~KILL_MASK;
                  r_out_valid <= 1'b0;
                  r_occ       <= 2'd0;
                  r_state     <= S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_emit) begin
                  r_main_ctrl <= r_skid_ctrl;
                  r_main_data <= r_skid_data;
                  r_in_ready  <= 1'b1;
                  r_occ       <= 2'd1;
                  r_state     <= S_ONE;
               end
            end
            default: begin
               r_state     <= S_EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_occ       <= 2'd0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_ctrl  = r_main_ctrl;
   assign out_data  = r_main_data;
   assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized and directed bench for pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;

   localparam int unsigned DBITS      = 32;
   localparam int unsigned CTRL_BITS  = 4;
   localparam int unsigned DATA_WORDS = 4;
   localparam int unsigned DW         = DBITS * DATA_WORDS;
   localparam logic [3:0]  KILL       = 4'b1010;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_ctrl;
   logic [DW-1:0] in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [3:0]    out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   pipe_stage_buf #(
      .DBITS      (DBITS),
      .CTRL_BITS  (CTRL_BITS),
      .DATA_WORDS (DATA_WORDS),
      .KILL_MASK  (KILL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]    c;
      logic [DW-1:0] d;
   } op_t;

   // Reference: FIFO of held ops, plus what main shows once it has gone empty.
   op_t q[$];
   op_t bub;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      op_t h;
      h = (q.size() > 0) ? q[0] : bub;
      check_val("out_valid", DW'(out_valid), DW'(q.size() > 0));
      check_val("in_ready", DW'(in_ready), DW'(q.size() < 2));
      check_val("occupancy", DW'(occupancy), DW'(q.size()));
      check_val("out_ctrl", DW'(out_ctrl), DW'(h.c));
      check_val("out_data", out_data, h.d);
      if (!out_valid)
         check_val("bubble", DW'(out_ctrl & KILL), '0);
   endtask

   task automatic model_clk(input logic v, input logic [3:0] c, input logic [DW-1:0] d,
                            input logic fl, input logic ordy);
      bit  acc;
      bit  em;
      op_t h;
      acc = v && (q.size() < 2);
      em  = ordy && (q.size() > 0);
      if (fl) begin
         if (q.size() > 0) begin
            bub.c = q[0].c & ~KILL;
            bub.d = q[0].d;
         end
         q.delete();
      end else begin
         if (em) begin
            h = q.pop_front();
            if (q.size() == 0) begin
               bub.c = h.c & ~KILL;
               bub.d = h.d;
            end
         end
         if (acc) q.push_back('{c: c, d: d});
      end
   endtask

   // Entered and left at a falling edge.
   task automatic drive_cycle(input logic v, input logic [3:0] c, input logic [DW-1:0] d,
                              input logic fl, input logic ordy);
      check_outputs();
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      flush     = fl;
      out_ready = ordy;
      @(posedge clk);
      model_clk(v, c, d, fl, ordy);
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] w2(input logic [31:0] x);
      return DW'(x) << 64;
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic random_run(input int unsigned cycles);
      logic          hv;
      logic [3:0]    hc;
      logic [DW-1:0] hd;
      logic          fl;
      logic          ordy;
      bit            taken;
      hv = 1'b0;
      hc = '0;
      hd = '0;
      for (int unsigned i = 0; i < cycles; i++) begin
         if (!hv) begin
            hv = ($urandom_range(0, 9) < 7);
            hc = 4'($urandom());
            hd = rnd_data();
         end
         fl    = ($urandom_range(0, 19) == 0);
         ordy  = ($urandom_range(0, 9) < 6);
         taken = hv && ((q.size() < 2) || fl);
         drive_cycle(hv, hc, hd, fl, ordy);
         if (taken) hv = 1'b0;
      end
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      bub       = '0;

      // Async reset seen before any clock edge
      #3 reset = 1'b1;
      #1;
      check_val("rst_out_valid", DW'(out_valid), '0);
      check_val("rst_in_ready", DW'(in_ready), DW'(1'b1));
      check_val("rst_occ", DW'(occupancy), '0);
      check_val("rst_ctrl", DW'(out_ctrl), '0);
      check_val("rst_data", out_data, '0);
      @(negedge clk);
      reset = 1'b0;
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b0);

      // Streaming with aluOut word 0x10..0x40
      for (int unsigned i = 1; i <= 4; i++)
         drive_cycle(1'b1, 4'(i), w2(32'(i * 16)), 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);

      // Back-pressure: A, B fill the buffer, C waits for in_ready
      drive_cycle(1'b1, 4'h1, w2(32'h11), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'h2, w2(32'h22), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'h3, w2(32'h33), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'h3, w2(32'h33), 1'b0, 1'b1);
      drive_cycle(1'b1, 4'h3, w2(32'h33), 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);

      // Flush with a full buffer and an op on offer
      drive_cycle(1'b1, 4'b0111, w2(32'h44), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'b1110, w2(32'h55), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'b1111, w2(32'h66), 1'b1, 1'b0);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);

      // Single op drains to empty with kill bits cleared
      drive_cycle(1'b1, 4'b1111, w2(32'h77), 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
      check_val("drain_ctrl", DW'(out_ctrl), DW'(4'b0101));

      random_run(2000);

      // Reset mid-operation with a full buffer
      drive_cycle(1'b1, 4'hF, rnd_data(), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'hE, rnd_data(), 1'b0, 1'b0);
      drive_cycle(1'b1, 4'hD, rnd_data(), 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      q.delete();
      bub = '0;
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      random_run(500);
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
